operand_stage: RTL and testbench
================================

Name: operand_stage

Overview:
- Decode/operand-fetch stage directly upstream of the 8-bit ALU.
- Accepts 9-bit instructions, decodes register fields, reads an 8x8 register file and registers opcode/rs/rt/immediate toward the ALU with a valid/ready handshake.
- Consumes the ALU's writeback (result, condition bit) into the register file and CB register.
- A busy scoreboard stalls issue on read-after-write hazards; same-cycle writebacks are bypassed.

Parameters:
NREGS, 8, register count (fixed at 8; register address is 3 bits)
DW, 8, register/data width

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
instr_valid_i  input  1  instruction present
instr_i  input  9  [8:5] opcode, [4:2] reg field, [4:0] immediate
instr_ready_o  output  1  stage accepts instruction this cycle
opcode_o  output  4  registered opcode to ALU
rs_o  output  8  registered first operand
rt_o  output  8  registered second operand
immediate_o  output  5  registered immediate
rd_o  output  3  destination register tag carried with the instruction
valid_o  output  1  output registers hold a valid instruction
ready_i  input  1  ALU side consumes the output this cycle
wb_en_i  input  1  register writeback strobe
wb_addr_i  input  3  writeback register
wb_data_i  input  8  writeback data (ALU result)
cb_en_i  input  1  condition-bit writeback strobe
cb_i  input  1  condition bit (ALU zero output)
cb_o  output  1  current condition bit register

Behaviour:
- Reset (async, rst_n_i low):
  - All 8 registers, cb_o, valid_o, opcode_o, rs_o, rt_o, immediate_o, rd_o and the busy[7:0] scoreboard clear to 0.
  - An in-flight instruction is dropped.
- Decode (R = instr_i[4:2]):
  - 0000 and, 0001 add, 0010 sll, 0011 srl: rs=R, rt=$r7, rd=R, writes reg.
  - 0110 abs: rs=R, rt=$r7 (ignored by ALU), rd=R, writes reg.
  - 0100 sub: rs=$r2, rt=$r5, rd=R, writes reg.
  - 0101 slt: rs=$r6, rt=$r7, writes CB only.
  - 0111 seq: rs=R, rt=$r7, writes CB only.
  - 1000 set: no sources, rd=$r0, writes reg; immediate_o=instr_i[4:0].
  - 1001 addc: rs=R, rt=$r7, rd=R, writes reg.
  - 1010-1111: no-op. Passes with valid_o, rs_o=rt_o=0, no sources, no writes.
- Operand read: combinational from the register file. If wb_en_i and wb_addr_i equals the source address in the same cycle, wb_data_i is used (bypass).
- Hazards:
  - hazard = a used source has busy[src]=1, unless wb_en_i clears that same register this cycle.
  - Additionally, a CB-writing instruction stalls while cb_busy=1, unless cb_en_i is asserted this cycle.
- Handshake:
  - instr_ready_o = (!valid_o | ready_i) & !hazard.
  - An instruction is accepted when instr_valid_i & instr_ready_o. Acceptance loads the output registers and sets valid_o=1 on the next edge.
  - If valid_o & !ready_i: output registers hold every field stable.
  - If ready_i & no accept: valid_o drops to 0 on the next edge.
  - Latency: accept at edge N puts operands on the outputs after edge N, one cycle.
- Scoreboard:
  - An accepted reg-writing instruction sets busy[rd]. An accepted CB-writing instruction sets cb_busy.
  - wb_en_i clears busy[wb_addr_i]. cb_en_i clears cb_busy and loads cb_o<=cb_i.
  - Same edge set and clear on the same register: set wins.
- Writeback: wb_en_i writes wb_data_i into reg[wb_addr_i] at the edge, independent of the handshake. Writeback to any of $r0-$r7 is allowed.
- A writeback arriving while the stage is stalled releases the stall that same cycle through the bypass.

Test Plan:
- Reset: drive rst_n_i low mid-cycle with valid_o=1 -> all outputs, cb_o and busy clear immediately. After release, instr_ready_o=1.
- Add: preload $r3=0x05, $r7=0x0A via wb. Issue 0001_011_00 -> next cycle opcode_o=0001, rs_o=0x05, rt_o=0x0A, rd_o=3, valid_o=1, busy[3]=1.
- RAW stall: issue add to $r3, then and on $r3 -> instr_ready_o=0 until wb_en_i with wb_addr_i=3, wb_data_i=0x0F. In that cycle the and is accepted with rs_o=0x0F (bypass).
- Backpressure: valid_o=1, ready_i=0 for 3 cycles with a new instruction waiting -> outputs unchanged, instr_ready_o=0. ready_i=1 -> new instruction loaded next edge.
- Set/sub decode: issue 1000_10110 -> immediate_o=0x16, rd_o=0, busy[0]=1. Issue sub with $r2=0x09, $r5=0x04 -> rs_o=0x09, rt_o=0x04.
- CB path: issue slt -> cb_busy=1; a second seq stalls. cb_en_i=1, cb_i=1 -> cb_o=1 next edge, and seq is accepted in the cb_en_i cycle.

Source files
------------

// File: rtl/operand_stage.sv
// operand_stage: decode / operand-fetch stage in front of the 8-bit ALU.
// Decodes a 9-bit instruction and reads two operands from an 8x8 register
// file, bypassing a same-cycle writeback. Operands are registered toward
// the ALU behind a valid/ready handshake. A busy scoreboard (one bit per
// register plus one for the condition bit) stalls issue on RAW hazards.
module operand_stage #(
    parameter int NREGS = 8,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          instr_valid_i,
    input  logic [8:0]    instr_i,
    output logic          instr_ready_o,
    output logic [3:0]    opcode_o,
    output logic [DW-1:0] rs_o,
    output logic [DW-1:0] rt_o,
    output logic [4:0]    immediate_o,
    output logic [2:0]    rd_o,
    output logic          valid_o,
    input  logic          ready_i,
    input  logic          wb_en_i,
    input  logic [2:0]    wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic          cb_en_i,
    input  logic          cb_i,
    output logic          cb_o
);

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SLL  = 4'h2;
    localparam logic [3:0] OP_SRL  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ABS  = 4'h6;
    localparam logic [3:0] OP_SEQ  = 4'h7;
    localparam logic [3:0] OP_SET  = 4'h8;
    localparam logic [3:0] OP_ADDC = 4'h9;

    // State
    logic [NREGS-1:0][DW-1:0] regs_q, regs_d;
    logic [NREGS-1:0]         busy_q, busy_d;
    logic                     cb_busy_q, cb_busy_d;
    logic                     cb_q, cb_d;
    logic                     valid_q, valid_d;
    logic [3:0]               opcode_q, opcode_d;
    logic [DW-1:0]            rs_q, rs_d;
    logic [DW-1:0]            rt_q, rt_d;
    logic [4:0]               imm_q, imm_d;
    logic [2:0]               rd_q, rd_d;

    // Decode results
    logic [3:0]    op_s;
    logic [2:0]    rfield_s;
    logic          uses_src_s;
    logic [2:0]    src_a_s;
    logic [2:0]    src_b_s;
    logic          wr_reg_s;
    logic          wr_cb_s;
    logic [2:0]    rd_s;

    // Operand / hazard / handshake
    logic [DW-1:0] opnd_a_s;
    logic [DW-1:0] opnd_b_s;
    logic          hazard_s;
    logic          ready_s;
    logic          accept_s;

    // Decode the instruction into source/destination registers and write kinds.
    always_comb begin
        op_s       = instr_i[8:5];
        rfield_s   = instr_i[4:2];
        uses_src_s = 1'b0;
        src_a_s    = 3'd0;
        src_b_s    = 3'd0;
        wr_reg_s   = 1'b0;
        wr_cb_s    = 1'b0;
        rd_s       = 3'd0;
        case (op_s)
            OP_AND, OP_ADD, OP_SLL, OP_SRL, OP_ABS, OP_ADDC: begin
                uses_src_s = 1'b1;
                src_a_s    = rfield_s;
                src_b_s    = 3'd7;
                wr_reg_s   = 1'b1;
                rd_s       = rfield_s;
            end
            OP_SUB: begin
                uses_src_s = 1'b1;
                src_a_s    = 3'd2;
                src_b_s    = 3'd5;
                wr_reg_s   = 1'b1;
                rd_s       = rfield_s;
            end
            OP_SLT: begin
                uses_src_s = 1'b1;
                src_a_s    = 3'd6;
                src_b_s    = 3'd7;
                wr_cb_s    = 1'b1;
                rd_s       = rfield_s;
            end
            OP_SEQ: begin
                uses_src_s = 1'b1;
                src_a_s    = rfield_s;
                src_b_s    = 3'd7;
                wr_cb_s    = 1'b1;
                rd_s       = rfield_s;
            end
            OP_SET: begin
                wr_reg_s   = 1'b1;
                rd_s       = 3'd0;
            end
            default: begin
                // 1010-1111 pass through as no-ops: no sources, no writes.
                uses_src_s = 1'b0;
            end
        endcase
    end

    // Read operands, substituting the writeback data when it targets the source.
    always_comb begin
        opnd_a_s = '0;
        opnd_b_s = '0;
        if (uses_src_s) begin
            if (wb_en_i && (wb_addr_i == src_a_s)) begin
                opnd_a_s = wb_data_i;
            end else begin
                opnd_a_s = regs_q[src_a_s];
            end
            if (wb_en_i && (wb_addr_i == src_b_s)) begin
                opnd_b_s = wb_data_i;
            end else begin
                opnd_b_s = regs_q[src_b_s];
            end
        end else begin
            opnd_a_s = '0;
            opnd_b_s = '0;
        end
    end

    // Hazard detection; a writeback this cycle releases its register immediately.
    always_comb begin
        hazard_s = 1'b0;
        if (uses_src_s && busy_q[src_a_s] && !(wb_en_i && (wb_addr_i == src_a_s))) begin
            hazard_s = 1'b1;
        end else if (uses_src_s && busy_q[src_b_s] && !(wb_en_i && (wb_addr_i == src_b_s))) begin
            hazard_s = 1'b1;
        end else if (wr_cb_s && cb_busy_q && !cb_en_i) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        ready_s  = (!valid_q || ready_i) && !hazard_s;
        accept_s = instr_valid_i && ready_s;
    end

    assign instr_ready_o = ready_s;

    // Next state of the output pipeline register.
    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        imm_d    = imm_q;
        rd_d     = rd_q;
        if (accept_s) begin
            valid_d  = 1'b1;
            opcode_d = op_s;
            rs_d     = opnd_a_s;
            rt_d     = opnd_b_s;
            imm_d    = instr_i[4:0];
            rd_d     = rd_s;
        end else if (ready_i) begin
            valid_d  = 1'b0;
        end else begin
            valid_d  = valid_q;
        end
    end

    // Next state of register file, scoreboard and condition bit; set beats clear.
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        cb_busy_d = cb_busy_q;
        cb_d      = cb_q;
        if (wb_en_i) begin
            regs_d[wb_addr_i] = wb_data_i;
            busy_d[wb_addr_i] = 1'b0;
        end else begin
            regs_d = regs_q;
        end
        if (cb_en_i) begin
            cb_busy_d = 1'b0;
            cb_d      = cb_i;
        end else begin
            cb_d      = cb_q;
        end
        if (accept_s && wr_reg_s) begin
            busy_d[rd_s] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        if (accept_s && wr_cb_s) begin
            cb_busy_d = 1'b1;
        end else begin
            cb_busy_d = cb_busy_d;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            regs_q    <= '0;
            busy_q    <= '0;
            cb_busy_q <= 1'b0;
            cb_q      <= 1'b0;
            valid_q   <= 1'b0;
            opcode_q  <= 4'd0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= 5'd0;
            rd_q      <= 3'd0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            cb_busy_q <= cb_busy_d;
            cb_q      <= cb_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
        end
    end

    assign valid_o     = valid_q;
    assign opcode_o    = opcode_q;
    assign rs_o        = rs_q;
    assign rt_o        = rt_q;
    assign immediate_o = imm_q;
    assign rd_o        = rd_q;
    assign cb_o        = cb_q;

endmodule

// File: tb/tb_operand_stage.sv
// Testbench for operand_stage: directed scenarios followed by random traffic,
// all checked against a behavioural model of the stage.
module tb_operand_stage;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       instr_valid_i;
    logic [8:0] instr_i;
    logic       instr_ready_o;
    logic [3:0] opcode_o;
    logic [7:0] rs_o;
    logic [7:0] rt_o;
    logic [4:0] immediate_o;
    logic [2:0] rd_o;
    logic       valid_o;
    logic       ready_i;
    logic       wb_en_i;
    logic [2:0] wb_addr_i;
    logic [7:0] wb_data_i;
    logic       cb_en_i;
    logic       cb_i;
    logic       cb_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [7:0] m_regs [8];
    bit         m_busy [8];
    bit         m_cbbusy;
    bit         m_cb;
    bit         m_valid;
    logic [3:0] m_op;
    logic [7:0] m_rs;
    logic [7:0] m_rt;
    logic [4:0] m_imm;
    logic [2:0] m_rd;
    bit         m_wr;
    bit         obs_ready;

    operand_stage dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .instr_ready_o (instr_ready_o),
        .opcode_o      (opcode_o),
        .rs_o          (rs_o),
        .rt_o          (rt_o),
        .immediate_o   (immediate_o),
        .rd_o          (rd_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .cb_en_i       (cb_en_i),
        .cb_i          (cb_i),
        .cb_o          (cb_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction semantics straight from the opcode table.
    function automatic void decode(input logic [8:0] ins, output bit uses, output logic [2:0] a,
                                   output logic [2:0] b, output bit wr, output bit wcb,
                                   output logic [2:0] rd);
        logic [3:0] op;
        logic [2:0] r;
        op = ins[8:5];
        r  = ins[4:2];
        uses = 0; a = 3'd0; b = 3'd0; wr = 0; wcb = 0; rd = r;
        if (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h9}) begin
            uses = 1; a = r; b = 3'd7; wr = 1;
        end else if (op == 4'h4) begin
            uses = 1; a = 3'd2; b = 3'd5; wr = 1;
        end else if (op == 4'h5) begin
            uses = 1; a = 3'd6; b = 3'd7; wcb = 1;
        end else if (op == 4'h7) begin
            uses = 1; a = r; b = 3'd7; wcb = 1;
        end else if (op == 4'h8) begin
            wr = 1; rd = 3'd0;
        end
    endfunction

    function automatic logic [7:0] read_src(input logic [2:0] s);
        return (wb_en_i && wb_addr_i == s) ? wb_data_i : m_regs[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 8'h00;
            m_busy[i] = 0;
        end
        m_cbbusy = 0; m_cb = 0; m_valid = 0; m_op = 4'h0;
        m_rs = 8'h00; m_rt = 8'h00; m_imm = 5'h00; m_rd = 3'h0; m_wr = 0;
    endtask

    task automatic check_outputs();
        check_eq("valid_o", valid_o, m_valid);
        check_eq("cb_o", cb_o, m_cb);
        if (m_valid) begin
            check_eq("opcode_o", opcode_o, m_op);
            check_eq("rs_o", rs_o, m_rs);
            check_eq("rt_o", rt_o, m_rt);
            check_eq("immediate_o", immediate_o, m_imm);
            if (m_wr) check_eq("rd_o", rd_o, m_rd);
        end
    endtask

    // One clock cycle: inputs already driven; check ready, advance model and DUT, check outputs.
    task automatic step();
        bit uses, wr, wcb, hz, exp_rdy, acc;
        logic [2:0] a, b, rd;
        logic [7:0] va, vb;
        decode(instr_i, uses, a, b, wr, wcb, rd);
        hz = 0;
        if (uses && m_busy[a] && !(wb_en_i && wb_addr_i == a)) hz = 1;
        if (uses && m_busy[b] && !(wb_en_i && wb_addr_i == b)) hz = 1;
        if (wcb && m_cbbusy && !cb_en_i) hz = 1;
        exp_rdy = (!m_valid || ready_i) && !hz;
        #1;
        obs_ready = instr_ready_o;
        check_eq("instr_ready_o", instr_ready_o, exp_rdy);
        acc = instr_valid_i && exp_rdy;
        va = uses ? read_src(a) : 8'h00;
        vb = uses ? read_src(b) : 8'h00;
        @(posedge clk_i);
        if (acc) begin
            m_valid = 1; m_op = instr_i[8:5]; m_rs = va; m_rt = vb;
            m_imm = instr_i[4:0]; m_rd = rd; m_wr = wr;
        end else if (ready_i) begin
            m_valid = 0;
        end
        if (wb_en_i) begin
            m_regs[wb_addr_i] = wb_data_i;
            m_busy[wb_addr_i] = 0;
        end
        if (cb_en_i) begin
            m_cbbusy = 0;
            m_cb = cb_i;
        end
        if (acc && wr) m_busy[rd] = 1;
        if (acc && wcb) m_cbbusy = 1;
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit iv, input logic [8:0] ins, input bit rdy,
                         input bit we, input logic [2:0] wa, input logic [7:0] wd,
                         input bit ce, input bit cv);
        instr_valid_i = iv; instr_i = ins; ready_i = rdy;
        wb_en_i = we; wb_addr_i = wa; wb_data_i = wd; cb_en_i = ce; cb_i = cv;
    endtask

    initial begin
        rst_n_i = 1'b0;
        drive(0, 9'h000, 1, 0, 3'd0, 8'h00, 0, 0);
        model_reset();
        #12;
        check_outputs();
        check_eq("reset_rd_o", rd_o, 3'd0);
        rst_n_i = 1'b1;

        // Preload $r3 = 0x05 and $r7 = 0x0A via writeback
        drive(0, 9'h000, 1, 1, 3'd3, 8'h05, 0, 0); step();
        drive(0, 9'h000, 1, 1, 3'd7, 8'h0A, 0, 0); step();

        // add $r3
        drive(1, 9'b0001_011_00, 1, 0, 3'd0, 8'h00, 0, 0); step();
        check_eq("add_opcode", opcode_o, 4'h1);
        check_eq("add_rs", rs_o, 8'h05);
        check_eq("add_rt", rt_o, 8'h0A);
        check_eq("add_rd", rd_o, 3'd3);

        // and $r3 stalls on the busy $r3 until its writeback arrives
        drive(1, 9'b0000_011_00, 1, 0, 3'd0, 8'h00, 0, 0); step();
        check_eq("raw_stall", obs_ready, 1'b0);
        step();
        check_eq("raw_stall2", obs_ready, 1'b0);
        drive(1, 9'b0000_011_00, 1, 1, 3'd3, 8'h0F, 0, 0); step();
        check_eq("raw_release", obs_ready, 1'b1);
        check_eq("raw_bypass_rs", rs_o, 8'h0F);

        // Backpressure: add $r1 waiting while the ALU is not ready
        drive(1, 9'b0001_001_00, 0, 0, 3'd0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_ready", obs_ready, 1'b0);
            check_eq("bp_hold_rs", rs_o, 8'h0F);
            check_eq("bp_hold_op", opcode_o, 4'h0);
        end
        drive(1, 9'b0001_001_00, 1, 0, 3'd0, 8'h00, 0, 0); step();
        check_eq("bp_load_op", opcode_o, 4'h1);
        check_eq("bp_load_rs", rs_o, 8'h00);
        check_eq("bp_load_rd", rd_o, 3'd1);

        // set, then sub reading $r2/$r5
        drive(1, 9'b1000_10110, 1, 0, 3'd0, 8'h00, 0, 0); step();
        check_eq("set_imm", immediate_o, 5'h16);
        check_eq("set_rd", rd_o, 3'd0);
        check_eq("set_rs", rs_o, 8'h00);
        drive(0, 9'h000, 1, 1, 3'd2, 8'h09, 0, 0); step();
        drive(0, 9'h000, 1, 1, 3'd5, 8'h04, 0, 0); step();
        drive(1, 9'b0100_000_00, 1, 0, 3'd0, 8'h00, 0, 0); step();
        check_eq("sub_rs", rs_o, 8'h09);
        check_eq("sub_rt", rt_o, 8'h04);

        // CB path: slt makes CB busy, seq waits for cb_en_i
        drive(0, 9'h000, 1, 1, 3'd1, 8'h33, 0, 0); step();
        drive(1, 9'b0101_000_00, 1, 0, 3'd0, 8'h00, 0, 0); step();
        check_eq("slt_op", opcode_o, 4'h5);
        drive(1, 9'b0111_001_00, 1, 0, 3'd0, 8'h00, 0, 0); step();
        check_eq("seq_stall", obs_ready, 1'b0);
        drive(1, 9'b0111_001_00, 1, 0, 3'd0, 8'h00, 1, 1); step();
        check_eq("seq_release", obs_ready, 1'b1);
        check_eq("cb_loaded", cb_o, 1'b1);
        check_eq("seq_op", opcode_o, 4'h7);
        check_eq("seq_rs", rs_o, 8'h33);

        // Asynchronous reset mid-cycle while valid_o is high
        drive(0, 9'b0000_011_00, 0, 0, 3'd0, 8'h00, 0, 0);
        #2 rst_n_i = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_opcode", opcode_o, 4'h0);
        check_eq("rst_rs", rs_o, 8'h00);
        check_eq("rst_rt", rt_o, 8'h00);
        check_eq("rst_imm", immediate_o, 5'h00);
        check_eq("rst_rd", rd_o, 3'd0);
        #1 rst_n_i = 1'b1;
        drive(1, 9'b0000_011_00, 1, 0, 3'd0, 8'h00, 0, 0); step();
        check_eq("post_rst_ready", obs_ready, 1'b1);
        check_eq("post_rst_rs", rs_o, 8'h00);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 9) < 7), 9'($urandom_range(0, 511)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
